// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU wrapper.
//   alu_op_e : 4-bit opcode set carried on req_op
//   state_e  : handshake FSM states of alu_seq_unit
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_DIV = 4'b0011,
    ALU_MOD = 4'b0100,
    ALU_AND = 4'b1000,
    ALU_OR  = 4'b1001,
    ALU_XOR = 4'b1010,
    ALU_LSL = 4'b1011,
    ALU_LSR = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

endpackage

// File: rtl/alu_div_iter.sv
// alu_div_iter: unsigned restoring divider, one quotient bit per clock.
//   clk, rst_n : shared clock / async active-low reset
//   start      : load dividend/divisor, clear the partial remainder
//   dividend   : NUM_BITS numerator
//   divisor    : NUM_BITS denominator (0 yields all-ones quotient, remainder = dividend)
//   quotient   : quotient after the step taken in the current cycle
//   remainder  : remainder after the step taken in the current cycle
// The outputs show the result of the step being committed this cycle, so the
// caller samples the final values on the same edge as the last step.
module alu_div_iter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NUM_BITS-1:0] dividend,
  input  logic [NUM_BITS-1:0] divisor,
  output logic [NUM_BITS-1:0] quotient,
  output logic [NUM_BITS-1:0] remainder
);

  logic [NUM_BITS-1:0] rem_q;
  logic [NUM_BITS-1:0] quo_q;
  logic [NUM_BITS-1:0] dvs_q;
  logic [NUM_BITS:0]   shifted;
  logic [NUM_BITS:0]   trial;
  logic                fits;

  // Shift the next dividend bit into the partial remainder and try a subtract.
  assign shifted   = {rem_q, quo_q[NUM_BITS-1]};
  assign trial     = shifted - {1'b0, dvs_q};
  assign fits      = ~trial[NUM_BITS];
  assign remainder = fits ? trial[NUM_BITS-1:0] : shifted[NUM_BITS-1:0];
  assign quotient  = {quo_q[NUM_BITS-2:0], fits};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (start) begin
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else begin
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered, valid/ready-handshaked ALU execution wrapper.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : request handshake (ready only in IDLE)
//   req_op, req_a, req_b : opcode (alu_pkg::alu_op_e), unsigned operands
//   rsp_valid/rsp_ready  : response handshake (valid only in RESP)
//   rsp_r, rsp_n/z/c/v   : result and flags, held stable until consumed
//   rsp_err              : divide-by-zero, only with ALU_DIVZERO_ERR_EN defined
// Optional feature macro: ALU_DIVZERO_ERR_EN (DIV/MOD by zero answers in one
// cycle with R=0 and rsp_err=1 instead of running the divider).
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [3:0]          req_op,
  input  logic [NUM_BITS-1:0] req_a,
  input  logic [NUM_BITS-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [NUM_BITS-1:0] rsp_r,
  output logic                rsp_n,
  output logic                rsp_z,
  output logic                rsp_c,
  output logic                rsp_v
`ifdef ALU_DIVZERO_ERR_EN
  ,
  output logic                rsp_err
`endif
);

  localparam int MSB = NUM_BITS - 1;
  localparam int CW  = (NUM_BITS > 2) ? $clog2(NUM_BITS) : 1;

  state_e                state;
  logic [CW-1:0]         cnt;
  logic                  is_mod;
  logic [NUM_BITS-1:0]   div_quo;
  logic [NUM_BITS-1:0]   div_rem;
  logic [NUM_BITS-1:0]   div_res;

  logic [NUM_BITS:0]     sum;
  logic [NUM_BITS:0]     dif;
  logic [2*NUM_BITS-1:0] prod;
  logic [2*NUM_BITS-1:0] shl;
  logic [2*NUM_BITS-1:0] shr;
  logic [NUM_BITS-1:0]   res;
  logic                  res_c;
  logic                  res_v;
  logic                  is_div;
  logic                  goes_busy;
`ifdef ALU_DIVZERO_ERR_EN
  logic                  div_zero;
`endif

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign is_div    = (req_op == ALU_DIV) || (req_op == ALU_MOD);
`ifdef ALU_DIVZERO_ERR_EN
  assign div_zero  = is_div && (req_b == '0);
  assign goes_busy = is_div && !div_zero;
`else
  assign goes_busy = is_div;
`endif

  assign sum  = {1'b0, req_a} + {1'b0, req_b};
  assign dif  = {1'b0, req_a} - {1'b0, req_b};
  assign prod = (2*NUM_BITS)'(req_a) * (2*NUM_BITS)'(req_b);
  // Double-width shifts: the bit just past the result window is the last bit
  // shifted out, and naturally reads 0 for a zero or over-range shift.
  assign shl  = (2*NUM_BITS)'(req_a) << req_b;
  assign shr  = {req_a, {NUM_BITS{1'b0}}} >> req_b;

  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (req_op)
      ALU_ADD: begin
        res   = sum[MSB:0];
        res_c = sum[NUM_BITS];
        res_v = (req_a[MSB] == req_b[MSB]) && (res[MSB] != req_a[MSB]);
      end
      ALU_SUB: begin
        res   = dif[MSB:0];
        res_c = ~dif[NUM_BITS];
        res_v = (req_a[MSB] != req_b[MSB]) && (res[MSB] != req_a[MSB]);
      end
      ALU_MUL: begin
        res   = prod[MSB:0];
        res_c = |prod[2*NUM_BITS-1:NUM_BITS];
      end
      ALU_AND: res = req_a & req_b;
      ALU_OR:  res = req_a | req_b;
      ALU_XOR: res = req_a ^ req_b;
      ALU_LSL: begin
        res   = shl[MSB:0];
        res_c = shl[NUM_BITS];
      end
      ALU_LSR: begin
        res   = shr[2*NUM_BITS-1:NUM_BITS];
        res_c = shr[NUM_BITS-1];
      end
      default: ; // DIV/MOD handled by divider; undefined opcodes give R=0
    endcase
  end

  alu_div_iter #(.NUM_BITS(NUM_BITS)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (req_ready && req_valid),
    .dividend  (req_a),
    .divisor   (req_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign div_res = is_mod ? div_rem : div_quo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      is_mod  <= 1'b0;
      rsp_r   <= '0;
      rsp_n   <= 1'b0;
      rsp_z   <= 1'b0;
      rsp_c   <= 1'b0;
      rsp_v   <= 1'b0;
`ifdef ALU_DIVZERO_ERR_EN
      rsp_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (goes_busy) begin
              cnt    <= CW'(NUM_BITS - 1);
              is_mod <= (req_op == ALU_MOD);
              state  <= BUSY;
            end else begin
              rsp_r   <= res;
              rsp_n   <= res[MSB];
              rsp_z   <= (res == '0);
              rsp_c   <= res_c;
              rsp_v   <= res_v;
`ifdef ALU_DIVZERO_ERR_EN
              rsp_err <= div_zero;
`endif
              state   <= RESP;
            end
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            rsp_r   <= div_res;
            rsp_n   <= div_res[MSB];
            rsp_z   <= (div_res == '0);
            rsp_c   <= 1'b0;
            rsp_v   <= 1'b0;
`ifdef ALU_DIVZERO_ERR_EN
            rsp_err <= 1'b0;
`endif
            state   <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: self-checking bench for alu_seq_unit (NUM_BITS=4).
// Directed cases from the datasheet examples plus randomized operations,
// all checked against an arithmetic reference model.
// Honours ALU_DIVZERO_ERR_EN when the design is built with it.
module tb_alu_seq_unit;

  localparam int W    = 4;
  localparam int MAXV = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = '0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_r;
  logic         rsp_n, rsp_z, rsp_c, rsp_v;
`ifdef ALU_DIVZERO_ERR_EN
  logic         rsp_err;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_seq_unit #(.NUM_BITS(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_r     (rsp_r),
    .rsp_n     (rsp_n),
    .rsp_z     (rsp_z),
    .rsp_c     (rsp_c),
    .rsp_v     (rsp_v)
`ifdef ALU_DIVZERO_ERR_EN
    ,
    .rsp_err   (rsp_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= MAXV / 2) ? x - MAXV : x;
  endfunction

  // Reference model from the opcode definitions using plain integer arithmetic.
  function automatic void ref_alu(input int op, input int a, input int b,
                                  output int r, output int c, output int v,
                                  output int e, output int lat);
    int s;
    r = 0; c = 0; v = 0; e = 0;
    case (op)
      0: begin
        s = a + b; r = s % MAXV; c = int'(s >= MAXV);
        s = sgn(a) + sgn(b); v = int'(s < -MAXV / 2 || s >= MAXV / 2);
      end
      1: begin
        r = (a - b + MAXV) % MAXV; c = int'(a >= b);
        s = sgn(a) - sgn(b); v = int'(s < -MAXV / 2 || s >= MAXV / 2);
      end
      2: begin
        s = a * b; r = s % MAXV; c = int'(s >= MAXV);
      end
      3, 4: begin
        if (b == 0) begin
`ifdef ALU_DIVZERO_ERR_EN
          r = 0; e = 1;
`else
          r = (op == 3) ? MAXV - 1 : a;
`endif
        end else begin
          r = (op == 3) ? a / b : a % b;
        end
      end
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: begin
        r = (b >= W) ? 0 : (a << b) % MAXV;
        c = (b >= 1 && b <= W) ? (a >> (W - b)) & 1 : 0;
      end
      12: begin
        r = (b >= W) ? 0 : a >> b;
        c = (b >= 1 && b <= W) ? (a >> (b - 1)) & 1 : 0;
      end
      default: r = 0;
    endcase
    lat = ((op == 3 || op == 4) && e == 0) ? W + 1 : 1;
  endfunction

  // Issue one request, measure latency, hold the response for 'hold' cycles,
  // then complete the response handshake.
  task automatic run_op(input string tag, input int op, input int a, input int b, input int hold);
    int r, c, v, e, lat, cyc;
    ref_alu(op, a, b, r, c, v, e, lat);
    req_op    = op[3:0];
    req_a     = a[W-1:0];
    req_b     = b[W-1:0];
    req_valid = 1'b1;
    cyc = 0;
    while (!req_ready && cyc < 20) begin
      @(posedge clk); #1; cyc++;
    end
    check($sformatf("%s_ready", tag), {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    check($sformatf("%s_lat", tag), cyc, lat);
    check($sformatf("%s_r", tag), 32'(rsp_r), r);
    check($sformatf("%s_n", tag), {31'b0, rsp_n}, 32'(r >= MAXV / 2));
    check($sformatf("%s_z", tag), {31'b0, rsp_z}, 32'(r == 0));
    check($sformatf("%s_c", tag), {31'b0, rsp_c}, c);
    check($sformatf("%s_v", tag), {31'b0, rsp_v}, v);
`ifdef ALU_DIVZERO_ERR_EN
    check($sformatf("%s_err", tag), {31'b0, rsp_err}, e);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s_hold_valid", tag), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("%s_hold_rdy", tag), {31'b0, req_ready}, 32'd0);
      check($sformatf("%s_hold_r", tag), 32'(rsp_r), r);
      check($sformatf("%s_hold_c", tag), {31'b0, rsp_c}, c);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check($sformatf("%s_done_valid", tag), {31'b0, rsp_valid}, 32'd0);
    check($sformatf("%s_done_rdy", tag), {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int ops [12] = '{0, 1, 2, 3, 4, 8, 9, 10, 11, 12, 5, 14};
    int r, c, v, e, lat;

    #2;
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_r", 32'(rsp_r), 32'd0);
    check("rst_nzcv", {28'b0, rsp_n, rsp_z, rsp_c, rsp_v}, 32'd0);
`ifdef ALU_DIVZERO_ERR_EN
    check("rst_err", {31'b0, rsp_err}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_9_6",   0, 9, 6, 0);
    run_op("lsl_6_2",  11, 6, 2, 0);
    run_op("sub_10_3",  1, 10, 3, 1);
    run_op("sub_3_10",  1, 3, 10, 0);
    run_op("div_15_3",  3, 15, 3, 0);
    run_op("mod_15_12", 4, 15, 12, 0);
    run_op("add_hold3", 0, 7, 7, 3);
    run_op("div_5_0",   3, 5, 0, 0);
    run_op("mod_5_0",   4, 5, 0, 0);
    run_op("undef_5",   5, 9, 3, 1);
    run_op("lsl_b4",   11, 9, 4, 0);
    run_op("lsr_b4",   12, 9, 4, 0);
    run_op("lsl_b5",   11, 15, 5, 0);
    run_op("lsr_b0",   12, 9, 0, 0);
    run_op("mul_15_15", 2, 15, 15, 0);

    // A request waiting during RESP must not be taken on the handshake edge.
    req_op = 4'd0; req_a = 4'd2; req_b = 4'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_op = 4'd1; req_a = 4'd12; req_b = 4'd5;
    check("b2b_first_valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b_first_r", 32'(rsp_r), 32'd5);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("b2b_gap_valid", {31'b0, rsp_valid}, 32'd0);
    check("b2b_gap_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("b2b_second_valid", {31'b0, rsp_valid}, 32'd1);
    check("b2b_second_r", 32'(rsp_r), 32'd7);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Asynchronous reset while a division is in flight.
    req_op = 4'd3; req_a = 4'd8; req_b = 4'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstbusy_pre_ready", {31'b0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rstbusy_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstbusy_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op("div_8_4", 3, 8, 4, 0);

    for (int i = 0; i < 200; i++) begin
      int op, a, b;
      op = ops[$urandom_range(0, 11)];
      a  = $urandom_range(0, MAXV - 1);
      b  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, MAXV - 1);
      run_op($sformatf("rnd%0d_op%0d_%0d_%0d", i, op, a, b), op, a, b, $urandom_range(0, 3));
    end

    ref_alu(0, 1, 1, r, c, v, e, lat);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
